// File: rtl/routing_initiator_lut_if.sv
// Request/response bus of the routing LUT. Optional table-programming signals
// exist only when ROUTING_LUT_PROG_EN is defined.
interface routing_initiator_lut_if #(
    parameter int ADDR_W   = 32,
    parameter int PATH_W   = 7,
    parameter int TGT_W    = 4,
    parameter int ERRCNT_W = 16
);
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_address;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [PATH_W-1:0]   rsp_path;
    logic [TGT_W-1:0]    rsp_target;
    logic                rsp_failed;
    logic [ERRCNT_W-1:0] err_count;
    logic                err_clear;
`ifdef ROUTING_LUT_PROG_EN
    logic                cfg_we;
    logic [3:0]          cfg_index;
    logic [ADDR_W-1:0]   cfg_base;
    logic [ADDR_W-1:0]   cfg_limit;
    logic [PATH_W-1:0]   cfg_path;
    logic [TGT_W-1:0]    cfg_target;
    logic                cfg_enable;
`endif

    modport master (
        output req_valid, req_address, rsp_ready, err_clear,
`ifdef ROUTING_LUT_PROG_EN
        output cfg_we, cfg_index, cfg_base, cfg_limit, cfg_path, cfg_target, cfg_enable,
`endif
        input  req_ready, rsp_valid, rsp_path, rsp_target, rsp_failed, err_count
    );

    modport slave (
        input  req_valid, req_address, rsp_ready, err_clear,
`ifdef ROUTING_LUT_PROG_EN
        input  cfg_we, cfg_index, cfg_base, cfg_limit, cfg_path, cfg_target, cfg_enable,
`endif
        output req_ready, rsp_valid, rsp_path, rsp_target, rsp_failed, err_count
    );
endinterface

// File: rtl/routing_initiator_lut.sv
// Registered address-to-route decoder with a saturating decode-error counter.
// Define ROUTING_LUT_PROG_EN to hold the window table in writable flops.
module routing_initiator_lut #(
    parameter int ADDR_W      = 32,
    parameter int PATH_W      = 7,
    parameter int TGT_W       = 4,
    parameter int NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  =
        {32'h40000000, 32'h30000000, 32'h20000000, 32'h1a000000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT =
        {32'h4fffffff, 32'h3fffffff, 32'h2fffffff, 32'h1fffffff},
    parameter logic [NUM_REGIONS*PATH_W-1:0] REGION_PATH  =
        {7'b0001000, 7'b0000100, 7'b0000010, 7'b0000001},
    parameter logic [NUM_REGIONS*TGT_W-1:0]  REGION_TGT   =
        {4'h3, 4'h2, 4'h1, 4'hc},
    parameter logic [NUM_REGIONS-1:0]        REGION_EN    = NUM_REGIONS'(1),
    parameter int ERRCNT_W    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    routing_initiator_lut_if.slave  bus
);

    logic [ADDR_W-1:0] w_base  [NUM_REGIONS];
    logic [ADDR_W-1:0] w_limit [NUM_REGIONS];
    logic [PATH_W-1:0] w_path  [NUM_REGIONS];
    logic [TGT_W-1:0]  w_tgt   [NUM_REGIONS];
    logic              w_en    [NUM_REGIONS];

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_tbl
`ifdef ROUTING_LUT_PROG_EN
        logic [ADDR_W-1:0] r_base, r_limit;
        logic [PATH_W-1:0] r_path;
        logic [TGT_W-1:0]  r_tgt;
        logic              r_en;

        // Indices at or beyond NUM_REGIONS never match any entry, so they are dropped.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_base  <= REGION_BASE[g*ADDR_W +: ADDR_W];
                r_limit <= REGION_LIMIT[g*ADDR_W +: ADDR_W];
                r_path  <= REGION_PATH[g*PATH_W +: PATH_W];
                r_tgt   <= REGION_TGT[g*TGT_W +: TGT_W];
                r_en    <= REGION_EN[g];
            end else if (bus.cfg_we && bus.cfg_index == 4'(g)) begin
                r_base  <= bus.cfg_base;
                r_limit <= bus.cfg_limit;
                r_path  <= bus.cfg_path;
                r_tgt   <= bus.cfg_target;
                r_en    <= bus.cfg_enable;
            end
        end

        assign w_base[g]  = r_base;
        assign w_limit[g] = r_limit;
        assign w_path[g]  = r_path;
        assign w_tgt[g]   = r_tgt;
        assign w_en[g]    = r_en;
`else
        assign w_base[g]  = REGION_BASE[g*ADDR_W +: ADDR_W];
        assign w_limit[g] = REGION_LIMIT[g*ADDR_W +: ADDR_W];
        assign w_path[g]  = REGION_PATH[g*PATH_W +: PATH_W];
        assign w_tgt[g]   = REGION_TGT[g*TGT_W +: TGT_W];
        assign w_en[g]    = REGION_EN[g];
`endif
    end

    logic              w_hit;
    logic [PATH_W-1:0] w_dec_path;
    logic [TGT_W-1:0]  w_dec_tgt;

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        w_hit      = 1'b0;
        w_dec_path = '0;
        w_dec_tgt  = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_en[i] && bus.req_address >= w_base[i] && bus.req_address <= w_limit[i]) begin
                w_hit      = 1'b1;
                w_dec_path = w_path[i];
                w_dec_tgt  = w_tgt[i];
            end
        end
    end

    logic                r_rsp_valid;
    logic [PATH_W-1:0]   r_rsp_path;
    logic [TGT_W-1:0]    r_rsp_tgt;
    logic                r_rsp_failed;
    logic [ERRCNT_W-1:0] r_err_count;
    logic                w_accept;

    assign bus.req_ready = !r_rsp_valid || bus.rsp_ready;
    assign w_accept      = bus.req_valid && bus.req_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_path   <= '0;
            r_rsp_tgt    <= '0;
            r_rsp_failed <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_path   <= w_dec_path;
            r_rsp_tgt    <= w_dec_tgt;
            r_rsp_failed <= !w_hit;
        end else if (bus.rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_err_count <= '0;
        else if (bus.err_clear)
            r_err_count <= '0;
        else if (w_accept && !w_hit && r_err_count != '1)
            r_err_count <= r_err_count + 1'b1;
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_path   = r_rsp_path;
    assign bus.rsp_target = r_rsp_tgt;
    assign bus.rsp_failed = r_rsp_failed;
    assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_routing_initiator_lut.sv
// Scoreboard bench for routing_initiator_lut: directed lookups push expected
// responses; a negedge monitor compares whatever the DUT presents.
module tb_routing_initiator_lut;
    localparam int ADDR_W = 32, PATH_W = 7, TGT_W = 4, NR = 4, EW = 4;

    typedef struct packed {
        logic [PATH_W-1:0] path;
        logic [TGT_W-1:0]  tgt;
        logic              failed;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   exp_err = 0;
    exp_t sb[$];

    routing_initiator_lut_if #(.ADDR_W(ADDR_W), .PATH_W(PATH_W), .TGT_W(TGT_W), .ERRCNT_W(EW)) bus ();

    // Region 1 overlaps region 0 around 0x1b000000; region 3 is disabled.
    routing_initiator_lut #(
        .ADDR_W(ADDR_W), .PATH_W(PATH_W), .TGT_W(TGT_W), .NUM_REGIONS(NR),
        .REGION_BASE ({32'h40000000, 32'h30000000, 32'h1b000000, 32'h1a000000}),
        .REGION_LIMIT({32'h4fffffff, 32'h3fffffff, 32'h1bffffff, 32'h1fffffff}),
        .REGION_PATH ({7'b0001000, 7'b0000100, 7'b0100000, 7'b0000001}),
        .REGION_TGT  ({4'h2, 4'h1, 4'h5, 4'hc}),
        .REGION_EN   (4'b0111),
        .ERRCNT_W(EW)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus(bus)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t hit(input logic [PATH_W-1:0] p, input logic [TGT_W-1:0] t);
        exp_t e;
        e.path = p; e.tgt = t; e.failed = 1'b0;
        return e;
    endfunction

    function automatic exp_t miss();
        exp_t e;
        e.path = '0; e.tgt = '0; e.failed = 1'b1;
        return e;
    endfunction

    always @(negedge i_clk) begin
        if (!i_rst && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
                check("rsp_path",   32'(bus.rsp_path),   32'(sb[0].path));
                check("rsp_target", 32'(bus.rsp_target), 32'(sb[0].tgt));
                check("rsp_failed", 32'(bus.rsp_failed), 32'(sb[0].failed));
                if (bus.rsp_ready) void'(sb.pop_front());
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic req(input logic [31:0] a, input exp_t e);
        int n = 0;
        bus.req_valid   = 1'b1;
        bus.req_address = a;
        forever begin
            @(negedge i_clk);
            if (bus.req_ready) break;
            if (++n > 100) begin
                check("req_timeout", 32'(bus.req_ready), 32'd1);
                break;
            end
        end
        if (bus.req_ready) begin
            sb.push_back(e);
            if (e.failed && exp_err < (1 << EW) - 1) exp_err++;
        end
        @(posedge i_clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge i_clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        #1;
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_err",   32'(bus.err_count), 32'd0);
        sb.delete();
        exp_err = 0;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    initial begin
        int t0;
        bus.req_valid = 1'b0;
        bus.req_address = '0;
        bus.rsp_ready = 1'b1;
        bus.err_clear = 1'b0;
`ifdef ROUTING_LUT_PROG_EN
        bus.cfg_we = 1'b0; bus.cfg_index = '0; bus.cfg_base = '0; bus.cfg_limit = '0;
        bus.cfg_path = '0; bus.cfg_target = '0; bus.cfg_enable = 1'b0;
`endif
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_valid",  32'(bus.rsp_valid),  32'd0);
        check("reset_path",   32'(bus.rsp_path),   32'd0);
        check("reset_target", 32'(bus.rsp_target), 32'd0);
        check("reset_failed", 32'(bus.rsp_failed), 32'd0);
        check("reset_err",    32'(bus.err_count),  32'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        req(32'h1a000000, hit(7'b0000001, 4'hc));
        check("latency_valid", 32'(bus.rsp_valid), 32'd1);
        req(32'h1fffffff, hit(7'b0000001, 4'hc));
        req(32'h20000000, miss());
        check("err_after_miss", 32'(bus.err_count), 32'd1);
        drain();

        // Stall: one response held while a second request waits.
        bus.rsp_ready = 1'b0;
        req(32'h30000000, hit(7'b0000100, 4'h1));
        bus.req_valid = 1'b1;
        bus.req_address = 32'h1a000010;
        repeat (3) begin
            @(negedge i_clk);
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge i_clk);
        #1 bus.rsp_ready = 1'b1;
        req(32'h1a000010, hit(7'b0000001, 4'hc));

        t0 = cyc;
        req(32'h1b000000, hit(7'b0000001, 4'hc));
        req(32'h3fffffff, hit(7'b0000100, 4'h1));
        req(32'h40000000, miss());
        req(32'h2fffffff, miss());
        check("b2b_cycles", 32'(cyc - t0), 32'd4);
        drain();
        check("err_count_3", 32'(bus.err_count), 32'(exp_err));

        while (exp_err < (1 << EW) - 1) req(32'h00000000, miss());
        drain();
        check("err_full", 32'(bus.err_count), 32'hf);
        req(32'hffffffff, miss());
        drain();
        check("err_saturated", 32'(bus.err_count), 32'hf);
        bus.err_clear = 1'b1;
        req(32'h00000004, miss());
        bus.err_clear = 1'b0;
        exp_err = 0;
        check("err_cleared", 32'(bus.err_count), 32'd0);
        drain();

        // Reset with a held response: it must vanish and not come back.
        bus.rsp_ready = 1'b0;
        req(32'h1a000000, hit(7'b0000001, 4'hc));
        @(negedge i_clk);
        pulse_reset();
        bus.rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            check("no_replay", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge i_clk);
        #1;

`ifdef ROUTING_LUT_PROG_EN
        bus.cfg_we = 1'b1; bus.cfg_index = 4'd1; bus.cfg_base = 32'h0;
        bus.cfg_limit = 32'hfff; bus.cfg_path = 7'b0000010; bus.cfg_target = 4'h3;
        bus.cfg_enable = 1'b1;
        req(32'h00000100, miss());
        bus.cfg_we = 1'b0;
        req(32'h00000100, hit(7'b0000010, 4'h3));
        bus.cfg_we = 1'b1; bus.cfg_index = 4'd4; bus.cfg_base = 32'h50000000;
        bus.cfg_limit = 32'h5fffffff;
        @(posedge i_clk);
        #1 bus.cfg_we = 1'b0;
        req(32'h50000000, miss());
        drain();
        pulse_reset();
        req(32'h00000100, miss());
        req(32'h1b000000, hit(7'b0000001, 4'hc));
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
